// File: rtl/life_matrix_scanner.sv
// Row-multiplexed LED matrix scanner for the Life board: snapshots cells once per frame, then drives rows one-hot with blanking gaps.
// Optional column PWM dimming is compiled in with LIFE_SCANNER_PWM_EN.
module life_matrix_scanner #(
  parameter int ROWS         = 8,
  parameter int COLS         = 8,
  parameter int ROW_CYCLES   = 1000,
  parameter int BLANK_CYCLES = 4,
  parameter int PWM_DUTY     = ROW_CYCLES / 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [ROWS*COLS-1:0] cells,
  output logic [ROWS-1:0]      rows,
  output logic [COLS-1:0]      cols,
  output logic                 frame_start,
  output logic                 frame_done
);

  localparam int DMAX = (ROW_CYCLES > BLANK_CYCLES) ? ROW_CYCLES : BLANK_CYCLES;
  localparam int DW   = $clog2(DMAX + 1);
  localparam int RW   = $clog2(ROWS);
  localparam logic [DW-1:0] ROW_LAST   = DW'(ROW_CYCLES - 1);
  localparam logic [DW-1:0] BLANK_LAST = DW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [RW-1:0] ROW_IDX_LAST = RW'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, SNAP, BLANK, DRIVE} state_t;

  state_t                 state_q, state_d;
  logic [RW-1:0]          row_q, row_d;
  logic [DW-1:0]          dwell_q, dwell_d;
  logic [ROWS*COLS-1:0]   snap_q, snap_d;
  logic [ROWS-1:0]        rows_q, rows_d;
  logic [COLS-1:0]        cols_q, cols_d;
  logic                   frame_start_q, frame_start_d;
  logic                   frame_done_q, frame_done_d;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    dwell_d = dwell_q;
    snap_d  = snap_q;
    case (state_q)
      IDLE: begin
        if (ena) state_d = SNAP;
      end
      SNAP: begin
        snap_d  = cells;
        row_d   = '0;
        dwell_d = '0;
        state_d = (BLANK_CYCLES > 0) ? BLANK : DRIVE;
      end
      BLANK: begin
        if (dwell_q == BLANK_LAST) begin
          dwell_d = '0;
          state_d = DRIVE;
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      DRIVE: begin
        if (dwell_q == ROW_LAST) begin
          dwell_d = '0;
          if (row_q == ROW_IDX_LAST) begin
            // Frame end is the only point where ena is honoured, so frames never truncate.
            row_d   = '0;
            state_d = ena ? SNAP : IDLE;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = (BLANK_CYCLES > 0) ? BLANK : DRIVE;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    rows_d        = '0;
    cols_d        = '0;
    frame_start_d = (state_d == SNAP);
    frame_done_d  = (state_d == DRIVE) && (row_d == ROW_IDX_LAST) && (dwell_d == ROW_LAST);
    if (state_d == DRIVE) begin
      rows_d[row_d] = 1'b1;
      cols_d        = snap_d[row_d*COLS +: COLS];
`ifdef LIFE_SCANNER_PWM_EN
      if (int'(dwell_d) >= PWM_DUTY) cols_d = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      row_q         <= '0;
      dwell_q       <= '0;
      snap_q        <= '0;
      rows_q        <= '0;
      cols_q        <= '0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      dwell_q       <= dwell_d;
      snap_q        <= snap_d;
      rows_q        <= rows_d;
      cols_q        <= cols_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign rows        = rows_q;
  assign cols        = cols_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_life_matrix_scanner.sv
// Bench for life_matrix_scanner: directed scenarios plus random stimulus against a frame-position reference model.
module tb_life_matrix_scanner;

  localparam int R    = 4;
  localparam int C    = 4;
  localparam int RC   = 3;
  localparam int BC   = 2;
  localparam int DUTY = 1;
  localparam int PER  = 1 + R * (BC + RC);

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [15:0] cells;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic        frame_start;
  logic        frame_done;

  always #5 clk = ~clk;

  life_matrix_scanner #(
    .ROWS(R), .COLS(C), .ROW_CYCLES(RC), .BLANK_CYCLES(BC), .PWM_DUTY(DUTY)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .cells(cells),
    .rows(rows), .cols(cols), .frame_start(frame_start), .frame_done(frame_done)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc_no = 0;
  int fs_cnt = 0;

  // Reference model: whether a frame is running and the cycle offset inside it.
  bit          m_on  = 1'b0;
  int          m_pos = 0;
  logic [15:0] m_snap = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_no);
  endtask

  task automatic model_step(input logic r, input logic e, input logic [15:0] c);
    if (!r) begin
      m_on   = 1'b0;
      m_pos  = 0;
      m_snap = '0;
    end else if (m_on) begin
      if (m_pos == PER - 1) begin
        if (e) m_pos = 0;
        else   m_on  = 1'b0;
      end else begin
        if (m_pos == 0) m_snap = c;
        m_pos++;
      end
    end else if (e) begin
      m_on  = 1'b1;
      m_pos = 0;
    end
  endtask

  task automatic compare_outputs();
    logic [3:0]  e_rows;
    logic [3:0]  e_cols;
    logic        e_fs;
    logic        e_fd;
    logic [15:0] sh;
    int k, r, o, d;
    e_rows = '0;
    e_cols = '0;
    e_fs   = 1'b0;
    e_fd   = 1'b0;
    if (m_on) begin
      if (m_pos == 0) begin
        e_fs = 1'b1;
      end else begin
        k = m_pos - 1;
        r = k / (BC + RC);
        o = k % (BC + RC);
        if (o >= BC) begin
          d      = o - BC;
          e_rows = 4'(1 << r);
          sh     = m_snap >> (r * C);
          e_cols = sh[3:0];
`ifdef LIFE_SCANNER_PWM_EN
          if (d >= DUTY) e_cols = '0;
`endif
          e_fd = (r == R - 1) && (d == RC - 1);
        end
      end
    end
    check("rows", 32'(rows), 32'(e_rows));
    check("cols", 32'(cols), 32'(e_cols));
    check("frame_start", 32'(frame_start), 32'(e_fs));
    check("frame_done", 32'(frame_done), 32'(e_fd));
  endtask

  task automatic cyc(input logic r, input logic e, input logic [15:0] c);
    rst   = r;
    ena   = e;
    cells = c;
    @(posedge clk);
    model_step(r, e, c);
    #1;
    cyc_no++;
    if (frame_start) fs_cnt++;
    compare_outputs();
  endtask

  task automatic run_to(input int target, input logic e, input logic [15:0] c);
    int n;
    n = 0;
    while (!(m_on && m_pos == target) && n < 100) begin
      cyc(1'b1, e, c);
      n++;
    end
    if (n >= 100) check("run_to_timeout", 32'(n), 32'(0));
  endtask

  initial begin
    int prev_fs;
    int fs_before;
    rst   = 1'b0;
    ena   = 1'b1;
    cells = 16'hA5C3;

    // Reset held: everything dark, no pulses.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 16'hA5C3);
    cyc(1'b1, 1'b1, 16'hA5C3);
    check("first_fs_after_release", 32'(frame_start), 32'(1));

    // Two and a bit continuous frames; frame period measured directly.
    prev_fs = cyc_no;
    for (int i = 0; i < 2 * PER + 2; i++) begin
      cyc(1'b1, 1'b1, 16'hA5C3);
      if (frame_start) begin
        check("frame_period", 32'(cyc_no - prev_fs), 32'(PER));
        prev_fs = cyc_no;
      end
    end

    // Tear immunity: board clears while row 1 is driving.
    run_to(0, 1'b1, 16'hFFFF);
    run_to(1 + (BC + RC) + BC + 1, 1'b1, 16'hFFFF);
    for (int i = 0; i < PER + 5; i++) cyc(1'b1, 1'b1, 16'h0000);

    // ena dropped during row 1: frame completes, then idle with no restart.
    run_to(0, 1'b1, 16'h3C96);
    run_to(1 + (BC + RC) + BC + 1, 1'b1, 16'h3C96);
    fs_before = fs_cnt;
    for (int i = 0; i < 40; i++) cyc(1'b1, 1'b0, 16'h3C96);
    check("no_restart_after_ena_low", 32'(fs_cnt - fs_before), 32'(0));
    check("idle_rows", 32'(rows), 32'(0));

    // Reset pulse mid-DRIVE of row 2, then restart.
    run_to(1 + 2 * (BC + RC) + BC + 1, 1'b1, 16'h5A5A);
    cyc(1'b0, 1'b1, 16'h5A5A);
    check("reset_mid_rows", 32'(rows), 32'(0));
    for (int i = 0; i < PER + 3; i++) cyc(1'b1, 1'b1, 16'h5A5A);

    // Random traffic: mostly enabled, occasional reset, board changes often.
    for (int i = 0; i < 800; i++) begin
      cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) != 0), 16'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/life_matrix_scanner.md
Name: life_matrix_scanner

Overview:
- Downstream consumer of the Game of Life cell array.
- Takes the flat vector of every cell's registered state and drives a row-multiplexed LED matrix: one row energised at a time, its column pattern on the column lines.
- Snapshots the board once per frame so a generation update mid-scan never tears the image.
- Pulses frame_start/frame_done so the generation controller can pace its ena.

Parameters:
ROWS, 8, matrix rows (>=2)
COLS, 8, matrix columns (>=1)
ROW_CYCLES, 1000, clock cycles a row is driven (>=1)
BLANK_CYCLES, 4, all-off cycles before each row for anti-ghosting (>=0)
PWM_DUTY, ROW_CYCLES/2, lit cycles per row when the PWM option is compiled in (0..ROW_CYCLES)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-low reset
ena  input  1  scan enable; low = display idles blank
cells  input  ROWS*COLS  cell states; cell (r,c) = cells[r*COLS+c], 1 = alive
rows  output  ROWS  one-hot row drive, active-high
cols  output  COLS  column drive for the active row, 1 = LED lit
frame_start  output  1  one-cycle pulse in the snapshot cycle
frame_done  output  1  one-cycle pulse in the last DRIVE cycle of row ROWS-1

Behaviour:
- Single clock domain.
- rst is synchronous and active-low, sampled on the rising clk edge. While low: FSM=IDLE, row index=0, dwell counter=0, snapshot=0, rows=0, cols=0, frame_start=0, frame_done=0.
- All outputs are registered and change only on clk edges, in step with the state register.
- Each output value holds exactly for the cycles the FSM is in the corresponding state.
- States and transitions:
  - IDLE: rows=0, cols=0. If ena=1, go to SNAP next cycle.
  - SNAP (1 cycle): latch cells into snapshot; frame_start=1; row=0; dwell=0. Next state is BLANK if BLANK_CYCLES>0, else DRIVE.
  - BLANK: rows=0, cols=0 for exactly BLANK_CYCLES cycles, then DRIVE with dwell=0.
  - DRIVE: rows = one-hot(row); cols = snapshot[row*COLS +: COLS]; lasts exactly ROW_CYCLES cycles.
    - On its last cycle, if row<ROWS-1: row++ and go to BLANK (or DRIVE if BLANK_CYCLES=0).
    - On its last cycle, if row==ROWS-1: frame_done=1, then go to SNAP if ena=1, else IDLE.
- Frame period under continuous ena: 1 + ROWS*(BLANK_CYCLES+ROW_CYCLES) cycles.
- Boundary conditions:
  - ena falling mid-frame: the current frame completes, then IDLE. Frames are never truncated.
  - ena rising during IDLE: SNAP on the next cycle.
  - cells changing outside SNAP: no effect on the current frame.
  - cells changing in the SNAP cycle: the value present at that edge is captured.
  - Rows never overlap. At least BLANK_CYCLES all-zero cycles separate consecutive rows; with BLANK_CYCLES=0 rows are back-to-back.
  - frame_done and frame_start are never high in the same cycle; SNAP follows frame_done by one cycle.
  - Reset asserted mid-frame: everything returns to IDLE state on that edge, outputs 0.
- Width rules:
  - Dwell counter width is $clog2(max(ROW_CYCLES,BLANK_CYCLES)+1).
  - Row index width is $clog2(ROWS).
  - Neither counter ever exceeds its terminal value and no wrap is observable.

Optional Feature:
- Macro LIFE_SCANNER_PWM_EN.
- Defined: during DRIVE, cols carries the snapshot pattern only while dwell < PWM_DUTY, and cols=0 for the remaining ROW_CYCLES-PWM_DUTY cycles. rows stays asserted for the full ROW_CYCLES.
  - PWM_DUTY=0: always dark.
  - PWM_DUTY=ROW_CYCLES: identical to the feature being undefined.
- Undefined: PWM_DUTY is ignored; cols is driven for the entire DRIVE interval.

Test Plan:
- Reset with ROWS=4, COLS=4, ROW_CYCLES=3, BLANK_CYCLES=2:
  - rst=0 for 3 cycles, ena=1 -> rows=0, cols=0, no pulses while in reset.
  - First frame_start is in the cycle after rst releases.
- Full frame: cells=16'hA5C3, ena held high (same parameters):
  - rows 0001/0010/0100/1000 each for 3 cycles.
  - cols = 3, C, 5, A respectively.
  - 2 blank cycles before each row.
  - frame_done 20 cycles after frame_start, next frame_start 1 cycle later (period 21).
- Tear immunity: change cells from 16'hFFFF to 16'h0000 while row 1 is driving:
  - Rows 2-3 still show F for that frame.
  - The next frame shows all-zero cols.
- ena dropped mid-frame (during row 1): frame completes through row 3 with frame_done, then IDLE with rows=0, cols=0 and no further frame_start.
- Reset mid-DRIVE of row 2: rst=0 for 1 cycle -> rows=0, cols=0 on that edge; with ena=1 the scan restarts at SNAP/row 0.
- LIFE_SCANNER_PWM_EN defined, ROW_CYCLES=4, PWM_DUTY=1, cells all 1:
  - Each row has cols=F for 1 cycle, then 0 for 3 cycles, while rows stays one-hot for 4 cycles.
  - PWM_DUTY=0 gives cols always 0.
